// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared state encoding, device address and word table for the WM8731 initializer
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [7:0] DEV_ADDR   = 8'h34;
    localparam int         WORD_COUNT = 9;
    localparam logic [3:0] LAST_WORD  = 4'(WORD_COUNT - 1);

    // Register writes for the codec, in the order they must be issued
    function automatic logic [15:0] word_lookup(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0017;
            4'd2:    w = 16'h0217;
            4'd3:    w = 16'h0815;
            4'd4:    w = 16'h0A00;
            4'd5:    w = 16'h0C00;
            4'd6:    w = 16'h0E42;
            4'd7:    w = 16'h1019;
            4'd8:    w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Bus levels for one quarter-period position: {scl, sda_pulled_low}
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] ph, input logic data);
        logic [1:0] drv;
        case (st)
            ST_START: drv = {1'b1, ph == 2'd1};
            ST_BYTE:  drv = {ph[1], ~data};
            ST_ACK:   drv = {ph[1], 1'b0};
            ST_STOP:  drv = {ph != 2'd0, ph != 2'd2};
            default:  drv = 2'b10;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - one-clk tick every CLK_DIV clk cycles
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Down-counter that reloads at CLK_DIV-1 after reaching zero; the zero cycle is the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= CW'(CLK_DIV - 1);
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/i2c_initializer.sv
// rtl/i2c_initializer.sv - I2C master that writes the fixed WM8731 configuration table after reset
module i2c_initializer
    import codec_cfg_pkg::*;
#(
    parameter int CLK_DIV   = 125,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic I2C_SCLK,
    inout  wire  I2C_SDAT,
    output logic busy,
    output logic done,
    output logic ack_error
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic          tick;
    logic          sda_in;

    state_t        state, state_next;
    logic [1:0]    phase, phase_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [1:0]    byte_idx, byte_idx_next;
    logic [3:0]    word_idx, word_idx_next;
    logic [RW-1:0] retry, retry_next;
    logic          nack, nack_next;
    logic          finish, finish_next;
    logic          busy_next, done_next, err_next;
    logic          scl, scl_next;
    logic          sda_low, sda_low_next;
    logic [15:0]   word_val;
    logic [7:0]    byte_val;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign I2C_SCLK = scl;
    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
    assign sda_in   = I2C_SDAT;

    // State and bus registers; reset releases the bus immediately without a STOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= 2'd0;
            bit_cnt   <= 3'd7;
            byte_idx  <= 2'd0;
            word_idx  <= 4'd0;
            retry     <= '0;
            nack      <= 1'b0;
            finish    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            scl       <= 1'b1;
            sda_low   <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            bit_cnt   <= bit_cnt_next;
            byte_idx  <= byte_idx_next;
            word_idx  <= word_idx_next;
            retry     <= retry_next;
            nack      <= nack_next;
            finish    <= finish_next;
            busy      <= busy_next;
            done      <= done_next;
            ack_error <= err_next;
            scl       <= scl_next;
            sda_low   <= sda_low_next;
        end
    end

    // Sequencer: each tick advances one quarter of an SCL period
    always_comb begin
        state_next    = state;
        phase_next    = phase;
        bit_cnt_next  = bit_cnt;
        byte_idx_next = byte_idx;
        word_idx_next = word_idx;
        retry_next    = retry;
        nack_next     = nack;
        finish_next   = finish;
        busy_next     = busy;
        done_next     = done;
        err_next      = ack_error;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_next    = ST_START;
                    phase_next    = 2'd0;
                    busy_next     = 1'b1;
                    word_idx_next = 4'd0;
                    retry_next    = '0;
                    finish_next   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (phase == 2'd1) begin
                        state_next    = ST_BYTE;
                        phase_next    = 2'd0;
                        byte_idx_next = 2'd0;
                        bit_cnt_next  = 3'd7;
                    end else begin
                        phase_next = phase + 2'd1;
                    end
                end
            end
            ST_BYTE: begin
                if (tick) begin
                    if (phase == 2'd3) begin
                        phase_next = 2'd0;
                        if (bit_cnt == 3'd0) begin
                            state_next = ST_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt - 3'd1;
                        end
                    end else begin
                        phase_next = phase + 2'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    // Sample at the end of the first SCL-high quarter; a released line is a NACK
                    if (phase == 2'd2) begin
                        nack_next = sda_in;
                    end
                    if (phase == 2'd3) begin
                        phase_next = 2'd0;
                        if (nack) begin
                            state_next = ST_STOP;
                            if (retry == RW'(MAX_RETRY)) begin
                                finish_next = 1'b1;
                                err_next    = 1'b1;
                            end else begin
                                retry_next = retry + RW'(1);
                            end
                        end else if (byte_idx == 2'd2) begin
                            state_next = ST_STOP;
                            if (word_idx == LAST_WORD) begin
                                finish_next = 1'b1;
                            end else begin
                                word_idx_next = word_idx + 4'd1;
                                retry_next    = '0;
                            end
                        end else begin
                            state_next    = ST_BYTE;
                            byte_idx_next = byte_idx + 2'd1;
                            bit_cnt_next  = 3'd7;
                        end
                    end else begin
                        phase_next = phase + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (phase == 2'd2) begin
                        state_next = ST_GAP;
                        phase_next = 2'd0;
                    end else begin
                        phase_next = phase + 2'd1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (phase == 2'd3) begin
                        phase_next = 2'd0;
                        if (finish) begin
                            state_next  = ST_DONE;
                            finish_next = 1'b0;
                            busy_next   = 1'b0;
                            done_next   = 1'b1;
                        end else begin
                            state_next = ST_START;
                        end
                    end else begin
                        phase_next = phase + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_next    = ST_IDLE;
                    busy_next     = 1'b1;
                    done_next     = 1'b0;
                    err_next      = 1'b0;
                    word_idx_next = 4'd0;
                    retry_next    = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus levels for the position being entered, registered so SCL/SDA never glitch
    always_comb begin
        word_val = word_lookup(word_idx_next);
        case (byte_idx_next)
            2'd0:    byte_val = DEV_ADDR;
            2'd1:    byte_val = word_val[15:8];
            default: byte_val = word_val[7:0];
        endcase
        {scl_next, sda_low_next} = bus_drive(state_next, phase_next, byte_val[bit_cnt_next]);
    end

endmodule

// File: tb/tb_i2c_initializer.sv
// tb/tb_i2c_initializer.sv - bus-level bench with ACK/NACK slave and transaction model
module tb_i2c_initializer;

    localparam int CD   = 4;
    localparam int MAXR = 3;
    localparam int NPLAN = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    logic I2C_SCLK, busy, done, ack_error;
    wire  sda_bus;
    logic slave_low = 1'b0;

    assign sda_bus = slave_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_initializer #(.CLK_DIV(CD), .MAX_RETRY(MAXR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .I2C_SCLK  (I2C_SCLK),
        .I2C_SDAT  (sda_bus),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // plan[t]: byte index the slave NACKs in transaction t of a run, 3 = ACK everything
    int plan [NPLAN];
    logic [15:0] words [9] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0815, 16'h0A00,
                               16'h0C00, 16'h0E42, 16'h1019, 16'h1201};
    logic [31:0] exp_q[$];
    logic        exp_err;
    logic [31:0] obs_q[$];
    int base_obs = 0;
    int base_txn = 0;

    // monitor state
    int   txn_cnt = 0;
    logic in_txn = 0, ack_phase = 0, rise_seen = 0;
    logic prev_scl = 1, prev_sda = 1, prev_busy = 0;
    logic scl_c, sda_c;
    int   bitcnt = 0, byte_idx = 0, cnt_since = 0, low_len = 0, high_len = 0, pidx;
    logic [7:0]  shreg = 0;
    logic [23:0] rbytes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: one entry {bytes_sent, addr, hi, lo} per START..STOP
    task automatic build_expected();
        int w, r, a;
        logic [15:0] wd;
        w = 0; r = 0; a = 0;
        exp_q.delete();
        exp_err = 1'b0;
        while (w < 9 && a < NPLAN) begin
            wd = words[w];
            case (plan[a])
                0:       exp_q.push_back({8'd1, 8'h34, 16'h0000});
                1:       exp_q.push_back({8'd2, 8'h34, wd[15:8], 8'h00});
                default: exp_q.push_back({8'd3, 8'h34, wd});
            endcase
            if (plan[a] < 3) begin
                if (r == MAXR) begin
                    exp_err = 1'b1;
                    break;
                end
                r++;
            end else begin
                w++;
                r = 0;
            end
            a++;
        end
    endtask

    function automatic logic [31:0] obs_at(input int i);
        if (base_obs + i < obs_q.size()) return obs_q[base_obs + i];
        return 32'hDEAD_BEEF;
    endfunction

    // Bus monitor, ACK/NACK slave and per-cycle output checks
    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 0; ack_phase = 0; rise_seen = 0; slave_low = 0;
            prev_scl = 1; prev_sda = 1; cnt_since = 0; prev_busy = 0;
        end else begin
            scl_c = I2C_SCLK;
            sda_c = sda_bus;
            cnt_since++;
            chk("busy_and_done", {31'b0, busy & done}, 32'd0);
            if (prev_busy && !busy) chk("done_when_busy_falls", {31'b0, done}, 32'd1);
            if (prev_scl && scl_c && prev_sda && !sda_c) begin
                in_txn = 1; bitcnt = 0; byte_idx = 0; rbytes = 0;
                ack_phase = 0; rise_seen = 0; slave_low = 0;
                txn_cnt++;
            end else if (prev_scl && scl_c && !prev_sda && sda_c) begin
                if (in_txn) obs_q.push_back({8'(byte_idx), rbytes});
                in_txn = 0; slave_low = 0;
            end else if (in_txn && !prev_scl && scl_c) begin
                low_len = cnt_since; cnt_since = 0; rise_seen = 1;
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], sda_c};
                    bitcnt++;
                end
            end else if (in_txn && prev_scl && !scl_c) begin
                high_len = cnt_since; cnt_since = 0;
                if (rise_seen) begin
                    chk("scl_low_time", low_len, 2 * CD);
                    chk("scl_high_time", high_len, 2 * CD);
                end
                rise_seen = 0;
                if (ack_phase) begin
                    ack_phase = 0; bitcnt = 0; slave_low = 0;
                end else if (bitcnt == 8) begin
                    case (byte_idx)
                        0:       rbytes[23:16] = shreg;
                        1:       rbytes[15:8]  = shreg;
                        default: rbytes[7:0]   = shreg;
                    endcase
                    pidx = txn_cnt - base_txn - 1;
                    slave_low = !(pidx >= 0 && pidx < NPLAN && plan[pidx] == byte_idx);
                    byte_idx++;
                    ack_phase = 1;
                end
            end
            prev_scl = scl_c; prev_sda = sda_c; prev_busy = busy;
        end
    end

    task automatic begin_run();
        build_expected();
        base_txn = txn_cnt;
        base_obs = obs_q.size();
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_done_low", {31'b0, done}, 32'd0);
        chk("restart_busy_high", {31'b0, busy}, 32'd1);
        chk("restart_err_low", {31'b0, ack_error}, 32'd0);
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int n;
        n = 0;
        while (!busy && n < 2 * CD + 2) begin @(negedge clk); n++; end
        chk({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (!done && n < 30000) begin @(negedge clk); n++; end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        repeat (300) @(negedge clk);
        chk({tag, "_txn_count"}, obs_q.size() - base_obs, exp_q.size());
        chk({tag, "_start_count"}, txn_cnt - base_txn, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk($sformatf("%s_txn%0d", tag, i), obs_at(i), exp_q[i]);
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ack_error"}, {31'b0, ack_error}, {31'b0, exp_err});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'b0, I2C_SCLK}, 32'd1);
        chk("rst_sda", {31'b0, sda_bus}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, ack_error}, 32'd0);

        for (int i = 0; i < NPLAN; i++) plan[i] = 3;
        begin_run();
        rst_n = 1'b1;
        finish_run("all_ack");
        chk("all_ack_n", obs_q.size() - base_obs, 32'd9);
        chk("all_ack_first", obs_at(0), 32'h03341E00);
        chk("all_ack_last", obs_at(8), 32'h03341201);

        for (int i = 0; i < NPLAN; i++) plan[i] = 3;
        plan[3] = 1;
        begin_run();
        pulse_restart();
        finish_run("nack_w3");
        chk("nack_w3_n", obs_q.size() - base_obs, 32'd10);
        chk("nack_w3_cut", obs_at(3), 32'h02340800);
        chk("nack_w3_resend", obs_at(4), 32'h03340815);

        for (int i = 0; i < NPLAN; i++) plan[i] = 0;
        begin_run();
        pulse_restart();
        finish_run("nack_addr");
        chk("nack_addr_n", obs_q.size() - base_obs, 32'd4);
        chk("nack_addr_last", obs_at(3), 32'h01340000);
        chk("nack_addr_err", {31'b0, ack_error}, 32'd1);

        for (int i = 0; i < NPLAN; i++) plan[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3;
        begin_run();
        pulse_restart();
        repeat (1500) @(negedge clk);
        if (busy) begin
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
        end
        finish_run("rand_low");

        for (int i = 0; i < NPLAN; i++) plan[i] = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 2) : 3;
        begin_run();
        pulse_restart();
        finish_run("rand_high");

        for (int i = 0; i < NPLAN; i++) plan[i] = 3;
        begin_run();
        pulse_restart();
        n = 0;
        while (n < 10000) begin
            @(negedge clk);
            #1;
            if (in_txn && txn_cnt - base_txn == 5 && byte_idx == 0 && bitcnt == 2 && !I2C_SCLK) break;
            n++;
        end
        chk("mid_reset_reached", {31'b0, n < 10000}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_scl", {31'b0, I2C_SCLK}, 32'd1);
        chk("mid_reset_sda", {31'b0, sda_bus}, 32'd1);
        chk("mid_reset_busy", {31'b0, busy}, 32'd0);
        chk("mid_reset_done", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        begin_run();
        rst_n = 1'b1;
        finish_run("after_reset");
        chk("after_reset_first", obs_at(0), 32'h03341E00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
